// File: rtl/bullet_scheduler.sv
// -----------------------------------------------------------------------------
// bullet_scheduler
//
// Shares one bullet datapath (plot/erase/move engine) across NUM_SLOTS bullet
// slots. On each frame_tick it services a pending fire request by spawning a
// bullet into the lowest free slot. It then walks every live slot in ascending
// order through erase -> move -> draw, using a start/done handshake with the
// datapath. A slot is retired when its move reports top_reached or collided.
//
// Optional build macro:
//   BULLET_AUTOFIRE_EN - while fire is held, fire_pend is re-armed in every
//                        SPAWN_CHK where the cooldown has expired.
//
// Ports:
//   clk, reset     - system clock, asynchronous active-high reset
//   fire           - fire key level; a rising edge arms a spawn request
//   frame_tick     - one-cycle pulse per frame; starts a scheduling pass
//   dp_start       - one-cycle pulse launching a datapath operation
//   dp_slot, dp_op - slot and operation (00 erase, 01 move, 10 draw, 11 spawn),
//                    stable from the dp_start cycle through the dp_done cycle
//   dp_done        - datapath completion pulse (only honoured in WAIT)
//   top_reached,
//   collided       - move results, sampled only with dp_done of a move
//   active_mask    - bit i set while slot i holds a live bullet
//   busy           - high whenever a scheduling pass is in progress
//   fire_dropped   - pulse: request discarded because every slot was full
//   tick_overrun   - pulse: frame_tick arrived while a pass was running
// -----------------------------------------------------------------------------
module bullet_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int COOLDOWN  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fire,
  input  logic                 frame_tick,
  output logic                 dp_start,
  output logic [SLOT_W-1:0]    dp_slot,
  output logic [1:0]           dp_op,
  input  logic                 dp_done,
  input  logic                 top_reached,
  input  logic                 collided,
  output logic [NUM_SLOTS-1:0] active_mask,
  output logic                 busy,
  output logic                 fire_dropped,
  output logic                 tick_overrun
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SPAWN_CHK = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT      = 3'd3,
    S_NEXT      = 3'd4
  } state_e;

  localparam logic [1:0] OP_ERASE = 2'b00;
  localparam logic [1:0] OP_MOVE  = 2'b01;
  localparam logic [1:0] OP_DRAW  = 2'b10;
  localparam logic [1:0] OP_SPAWN = 2'b11;

  // The scan counter is one bit wider than a slot index so it can step past
  // the last slot and signal the end of the pass.
  localparam int              SCW           = SLOT_W + 1;
  localparam logic [SCW-1:0]  SLOT_END      = SCW'(NUM_SLOTS);
  localparam logic [SCW-1:0]  SLOT_ONE      = SCW'(1);
  localparam logic [7:0]      COOLDOWN_LOAD = 8'(COOLDOWN);

  state_e                 state_q, state_d;
  logic [SCW-1:0]         slot_q, slot_d;
  logic [1:0]             op_q, op_d;
  logic [NUM_SLOTS-1:0]   active_q, active_d;
  logic                   fire_pend_q, fire_pend_d;
  logic                   fire_prev_q, fire_prev_d;
  logic [7:0]             cooldown_q, cooldown_d;
  logic                   dp_start_q, dp_start_d;
  logic                   busy_q, busy_d;
  logic                   fire_dropped_q, fire_dropped_d;
  logic                   tick_overrun_q, tick_overrun_d;

  logic                   fire_rise_s;
  logic                   auto_s;
  logic                   pend_eff_s;
  logic                   has_free_s;
  logic [SLOT_W-1:0]      free_idx_s;
  logic [SLOT_W-1:0]      slot_idx_s;

  // Lowest-index clear bit of the occupancy mask (only meaningful if one exists).
  function automatic logic [SLOT_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] m);
    logic [SLOT_W-1:0] idx;
    idx = {SLOT_W{1'b0}};
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!m[i]) idx = SLOT_W'(i);
    end
    return idx;
  endfunction

  assign fire_rise_s = fire & ~fire_prev_q;
  assign has_free_s  = ~(&active_q);
  assign free_idx_s  = lowest_free(active_q);
  assign slot_idx_s  = slot_q[SLOT_W-1:0];

`ifdef BULLET_AUTOFIRE_EN
  assign auto_s = fire & (cooldown_q == 8'd0);
`else
  assign auto_s = 1'b0;
`endif

  // A request that rises in the SPAWN_CHK cycle itself still counts for this frame.
  assign pend_eff_s = fire_pend_q | fire_rise_s | auto_s;

  // Next-state and next-output computation for the scheduler.
  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    op_d           = op_q;
    active_d       = active_q;
    fire_prev_d    = fire;
    fire_pend_d    = fire_pend_q | fire_rise_s;
    fire_dropped_d = 1'b0;
    tick_overrun_d = frame_tick & (state_q != S_IDLE);

    if (frame_tick && (cooldown_q != 8'd0)) begin
      cooldown_d = cooldown_q - 8'd1;
    end else begin
      cooldown_d = cooldown_q;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_SPAWN_CHK;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SPAWN_CHK: begin
        if (pend_eff_s && (cooldown_q == 8'd0) && has_free_s) begin
          fire_pend_d = 1'b1;
          slot_d      = {1'b0, free_idx_s};
          op_d        = OP_SPAWN;
          state_d     = S_ISSUE;
        end else begin
          if (pend_eff_s && (cooldown_q == 8'd0)) begin
            fire_dropped_d = 1'b1;
            fire_pend_d    = 1'b0;
          end else begin
            fire_pend_d = fire_pend_q | fire_rise_s;
          end
          slot_d  = {SCW{1'b0}};
          op_d    = OP_ERASE;
          state_d = S_NEXT;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (dp_done) begin
          case (op_q)
            OP_SPAWN: begin
              active_d[slot_idx_s] = 1'b1;
              cooldown_d           = COOLDOWN_LOAD;
              // A fresh press landing on this very cycle stays armed.
              fire_pend_d          = fire_rise_s;
              slot_d               = {SCW{1'b0}};
              op_d                 = OP_ERASE;
              state_d              = S_NEXT;
            end
            OP_ERASE: begin
              op_d    = OP_MOVE;
              state_d = S_ISSUE;
            end
            OP_MOVE: begin
              if (top_reached || collided) begin
                active_d[slot_idx_s] = 1'b0;
                slot_d               = slot_q + SLOT_ONE;
                op_d                 = OP_ERASE;
                state_d              = S_NEXT;
              end else begin
                op_d    = OP_DRAW;
                state_d = S_ISSUE;
              end
            end
            OP_DRAW: begin
              slot_d  = slot_q + SLOT_ONE;
              op_d    = OP_ERASE;
              state_d = S_NEXT;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_WAIT;
        end
      end

      S_NEXT: begin
        if (slot_q >= SLOT_END) begin
          state_d = S_IDLE;
        end else if (active_q[slot_idx_s]) begin
          state_d = S_ISSUE;
        end else begin
          slot_d  = slot_q + SLOT_ONE;
          state_d = S_NEXT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    dp_start_d = (state_d == S_ISSUE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and registered-output flops; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      slot_q         <= {SCW{1'b0}};
      op_q           <= OP_ERASE;
      active_q       <= {NUM_SLOTS{1'b0}};
      fire_pend_q    <= 1'b0;
      fire_prev_q    <= 1'b0;
      cooldown_q     <= 8'd0;
      dp_start_q     <= 1'b0;
      busy_q         <= 1'b0;
      fire_dropped_q <= 1'b0;
      tick_overrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      op_q           <= op_d;
      active_q       <= active_d;
      fire_pend_q    <= fire_pend_d;
      fire_prev_q    <= fire_prev_d;
      cooldown_q     <= cooldown_d;
      dp_start_q     <= dp_start_d;
      busy_q         <= busy_d;
      fire_dropped_q <= fire_dropped_d;
      tick_overrun_q <= tick_overrun_d;
    end
  end

  assign dp_start     = dp_start_q;
  assign dp_slot      = slot_idx_s;
  assign dp_op        = op_q;
  assign active_mask  = active_q;
  assign busy         = busy_q;
  assign fire_dropped = fire_dropped_q;
  assign tick_overrun = tick_overrun_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bullet_scheduler
//
// Self-checking bench for bullet_scheduler. A frame-level reference model
// predicts, for every frame, the ordered list of datapath operations and the
// resulting occupancy; predictions go into a queue that a monitor drains each
// time the DUT pulses dp_start. A responder acts as the datapath, answering
// each operation after a random delay and reporting move outcomes chosen by
// the model.
// -----------------------------------------------------------------------------
module tb_bullet_scheduler;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int CD = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          fire;
  logic          frame_tick;
  logic          dp_start;
  logic [SW-1:0] dp_slot;
  logic [1:0]    dp_op;
  logic          dp_done;
  logic          top_reached;
  logic          collided;
  logic [N-1:0]  active_mask;
  logic          busy;
  logic          fire_dropped;
  logic          tick_overrun;

  always #5 clk = ~clk;

  bullet_scheduler #(.NUM_SLOTS(N), .SLOT_W(SW), .COOLDOWN(CD)) dut (
    .clk          (clk),
    .reset        (reset),
    .fire         (fire),
    .frame_tick   (frame_tick),
    .dp_start     (dp_start),
    .dp_slot      (dp_slot),
    .dp_op        (dp_op),
    .dp_done      (dp_done),
    .top_reached  (top_reached),
    .collided     (collided),
    .active_mask  (active_mask),
    .busy         (busy),
    .fire_dropped (fire_dropped),
    .tick_overrun (tick_overrun)
  );

  typedef struct packed {
    logic [SW-1:0] slot;
    logic [1:0]    op;
  } op_t;

  op_t        exp_q[$];
  logic [1:0] retire_q[$];   // {top_reached, collided} for each predicted move

  int passed = 0;
  int total  = 0;

  // Reference-model state
  bit [N-1:0] m_mask;
  bit         m_pend;
  int         m_cd;
  int         m_drops;
  int         m_ovr;
  int         retire_pct;

  // Observed event counters (monitor)
  int drop_seen    = 0;
  int overrun_seen = 0;
  int start_seen   = 0;
  int spawn_seen   = 0;

  bit resp_en      = 1'b0;
  int stray_cnt    = 0;
  int stray_served = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: compares every dp_start against the head of the expectation queue.
  initial begin
    forever begin
      @(negedge clk);
      if (fire_dropped === 1'b1) drop_seen++;
      if (tick_overrun === 1'b1) overrun_seen++;
      if (dp_start === 1'b1) begin
        start_seen++;
        if (dp_op == 2'b11) spawn_seen++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL dp_start_unexpected: got slot %0d op %0d, expected no operation", dp_slot, dp_op);
        end else begin
          op_t e;
          e = exp_q.pop_front();
          check("dp_slot_op", {28'd0, dp_slot, dp_op}, {28'd0, e.slot, e.op});
        end
      end
    end
  end

  // Responder: models the datapath, answering each launch after 1..3 cycles.
  initial begin
    dp_done     = 1'b0;
    top_reached = 1'b0;
    collided    = 1'b0;
    forever begin
      @(negedge clk);
      dp_done     = 1'b0;
      top_reached = 1'b0;
      collided    = 1'b0;
      if (stray_cnt != stray_served) begin
        dp_done = 1'b1;
        stray_served++;
      end else if (resp_en && dp_start === 1'b1) begin
        logic [1:0] op;
        logic [1:0] r;
        op = dp_op;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        r = 2'($urandom_range(0, 3));   // don't-care for non-move ops
        if (op == 2'b01) r = (retire_q.size() > 0) ? retire_q.pop_front() : 2'b00;
        dp_done = 1'b1;
        {top_reached, collided} = r;
      end
    end
  end

  task automatic push_op(input int slot, input logic [1:0] op);
    op_t e;
    e.slot = SW'(slot);
    e.op   = op;
    exp_q.push_back(e);
  endtask

  // Frame-level reference: what one frame_tick does to occupancy and cooldown.
  task automatic model_frame(input bit rise, input bit ovr, input bit fire_level);
    int spawn;
    spawn = -1;
    if (rise) m_pend = 1'b1;
    if (m_cd > 0) m_cd--;
`ifdef BULLET_AUTOFIRE_EN
    if (fire_level && m_cd == 0) m_pend = 1'b1;
`else
    if (fire_level && 1'b0) m_pend = 1'b1;
`endif
    if (m_pend && m_cd == 0) begin
      for (int s = 0; s < N; s++) if (!m_mask[s] && spawn < 0) spawn = s;
      if (spawn < 0) begin
        m_drops++;
        m_pend = 1'b0;
      end
    end
    if (ovr) begin
      m_ovr++;
      if (m_cd > 0) m_cd--;
    end
    if (spawn >= 0) begin
      push_op(spawn, 2'b11);
      m_mask[spawn] = 1'b1;
      m_cd   = CD;
      m_pend = 1'b0;
    end
    for (int s = 0; s < N; s++) begin
      if (m_mask[s]) begin
        push_op(s, 2'b00);
        push_op(s, 2'b01);
        if ($urandom_range(0, 99) < retire_pct) begin
          retire_q.push_back(2'($urandom_range(1, 3)));
          m_mask[s] = 1'b0;
        end else begin
          retire_q.push_back(2'b00);
          push_op(s, 2'b10);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++;
      $display("FAIL %s: busy still high after %0d cycles, expected idle", name, n);
    end
  endtask

  // fmode: 0 no fire change, 1 pulse before tick, 2 pulse with tick, 3 press and hold at tick
  task automatic run_frame(input int fmode, input bit ovr);
    bit rise;
    rise = 1'b0;
    if (fmode == 1) begin
      fire = 1'b1;
      @(negedge clk);
      fire = 1'b0;
      rise = 1'b1;
      @(negedge clk);
    end
    frame_tick = 1'b1;
    if (fmode == 2 || fmode == 3) begin
      fire = 1'b1;
      rise = 1'b1;
    end
    @(negedge clk);
    frame_tick = 1'b0;
    if (fmode == 2) fire = 1'b0;
    model_frame(rise, ovr, fire);
    @(negedge clk);
    if (ovr) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
    wait_idle("frame_end");
    @(negedge clk);
    check("active_mask", {28'd0, active_mask}, {28'd0, m_mask});
    check("fire_dropped_count", drop_seen, m_drops);
    check("tick_overrun_count", overrun_seen, m_ovr);
    check("ops_outstanding", exp_q.size(), 0);
    check("moves_outstanding", retire_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    m_mask = '0;
    m_pend = 1'b0;
    m_cd   = 0;
    exp_q.delete();
    retire_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int s0;
    int n;
    fire       = 1'b0;
    frame_tick = 1'b0;
    retire_pct = 0;
    m_drops    = 0;
    m_ovr      = 0;
    do_reset();

    // Reset state
    check("rst_active_mask", {28'd0, active_mask}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dp_start", {31'd0, dp_start}, 32'd0);
    check("rst_pulses", {30'd0, fire_dropped, tick_overrun}, 32'd0);

    // Reset while waiting on the datapath, then a stray dp_done afterwards
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    push_op(0, 2'b11);
    n = 0;
    while (dp_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("spawn_issue_seen", {31'd0, dp_start}, 32'd1);
    @(negedge clk);
    check("busy_in_wait", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_mask", {28'd0, active_mask}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    stray_cnt++;
    repeat (3) @(negedge clk);
    check("stray_done_busy", {31'd0, busy}, 32'd0);
    check("stray_done_start", {31'd0, dp_start}, 32'd0);
    check("stray_done_mask", {28'd0, active_mask}, 32'd0);
    m_mask = '0;
    m_pend = 1'b0;
    m_cd   = 0;
    exp_q.delete();
    resp_en = 1'b1;

    // Single spawn: spawn0, erase0, move0, draw0
    s0 = start_seen;
    run_frame(1, 1'b0);
    check("spawn_frame_starts", start_seen - s0, 4);

    // Fire every frame with no retirements: fills all slots, then drops
    for (int f = 0; f < 32; f++) run_frame(1, 1'b0);
    check("all_slots_full", {28'd0, active_mask}, 32'hF);
    check("drop_seen_nonzero", {31'd0, (drop_seen > 0)}, 32'd1);

    // Randomized frames with retirements, overruns and mixed fire timing
    retire_pct = 35;
    for (int f = 0; f < 40; f++) begin
      run_frame($urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    // Hold fire for 20 frames starting from empty slots
    do_reset();
    retire_pct = 100;
    s0 = spawn_seen;
    run_frame(3, 1'b0);
    for (int f = 1; f < 20; f++) run_frame(0, 1'b0);
`ifdef BULLET_AUTOFIRE_EN
    check("held_fire_spawns", spawn_seen - s0, 3);
`else
    check("held_fire_spawns", spawn_seen - s0, 1);
`endif
    fire = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute guard against a hung run
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
